// File: rtl/lcd_pkg.sv
// Shared HD44780 bus definitions for the LCD read and write engines.
// Holds the read FSM encoding, bus constants and default timing counts.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HIGH,
    ST_EN_LOW,
    ST_DONE
  } rd_state_e;

  localparam int   BF_BIT   = 7;
  localparam logic RS_CMD   = 1'b0;
  localparam logic RS_DATA  = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int LCD_SETUP_CYC   = 4;
  localparam int LCD_EN_HIGH_CYC = 16;
  localparam int LCD_EN_LOW_CYC  = 16;
  localparam int LCD_POLL_MAX    = 1023;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_read_ctrl.sv
// HD44780 read-cycle engine: single BF/address or data reads,
// or busy-flag polling with a bounded number of E pulses.
module lcd_read_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = LCD_SETUP_CYC,
  parameter int EN_HIGH_CYC = LCD_EN_HIGH_CYC,
  parameter int EN_LOW_CYC  = LCD_EN_LOW_CYC,
  parameter int POLL_MAX    = LCD_POLL_MAX
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       istart,
  input  logic       irs,
  input  logic       ipoll,
  output logic       odone,
  output logic [7:0] odata,
  output logic       otimeout,
  output logic       obusy,
  input  logic [7:0] lcd_data_i,
  output logic       obus_rel,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int MAXC = max3(SETUP_CYC, EN_HIGH_CYC, EN_LOW_CYC);
  localparam int PW   = $clog2(MAXC + 1);
  localparam int CW   = $clog2(POLL_MAX + 1);

  localparam logic [PW-1:0] SU_LAST = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] EH_LAST = PW'(EN_HIGH_CYC - 1);
  localparam logic [PW-1:0] EL_LAST = PW'(EN_LOW_CYC - 1);
  localparam logic [CW-1:0] CN_LAST = CW'(POLL_MAX - 1);

  rd_state_e     state_q;
  logic [PW-1:0] ph_q;
  logic [CW-1:0] cnt_q;
  logic          istart_q;
  logic          poll_q;
  logic          rs_q;
  logic          rw_q;
  logic          en_q;
  logic          rel_q;
  logic          done_q;
  logic          to_q;
  logic          busy_q;
  logic [7:0]    data_q;
  logic          start_d;

  assign start_d = istart & ~istart_q;

  // Read sequencer: phase timing, poll retries and registered bus outputs
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q  <= ST_IDLE;
      ph_q     <= '0;
      cnt_q    <= '0;
      istart_q <= 1'b1;
      poll_q   <= 1'b0;
      rs_q     <= RS_CMD;
      rw_q     <= RW_WRITE;
      en_q     <= 1'b0;
      rel_q    <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      istart_q <= istart;
      done_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            poll_q  <= ipoll & ~irs;
            rs_q    <= irs ? RS_DATA : RS_CMD;
            rw_q    <= RW_READ;
            rel_q   <= 1'b1;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            ph_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_q == SU_LAST) begin
            ph_q    <= '0;
            en_q    <= 1'b1;
            state_q <= ST_EN_HIGH;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_EN_HIGH: begin
          if (ph_q == EH_LAST) begin
            ph_q    <= '0;
            en_q    <= 1'b0;
            data_q  <= lcd_data_i;
            state_q <= ST_EN_LOW;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_EN_LOW: begin
          if (ph_q == EL_LAST) begin
            ph_q <= '0;
            if (poll_q && data_q[BF_BIT] && cnt_q != CN_LAST) begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= ST_SETUP;
            end else begin
              to_q    <= poll_q & data_q[BF_BIT];
              rw_q    <= RW_WRITE;
              rs_q    <= RS_CMD;
              rel_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign odone    = done_q;
  assign odata    = data_q;
  assign otimeout = to_q;
  assign obusy    = busy_q;
  assign obus_rel = rel_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = rw_q;
  assign lcd_en   = en_q;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Bench for lcd_read_ctrl: directed and random reads checked
// against a per-transaction model of pulses, latency and result.
module tb_lcd_read_ctrl;

  localparam int SU  = 4;
  localparam int EH  = 16;
  localparam int EL  = 16;
  localparam int PM  = 4;
  localparam int PER = SU + EH + EL;

  logic       iclk;
  logic       irst_n;
  logic       istart;
  logic       irs;
  logic       ipoll;
  logic       odone;
  logic [7:0] odata;
  logic       otimeout;
  logic       obusy;
  logic [7:0] lcd_data_i;
  logic       obus_rel;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  int checks;
  int errors;
  logic [7:0] vals [0:15];

  lcd_read_ctrl #(
    .SETUP_CYC  (SU),
    .EN_HIGH_CYC(EH),
    .EN_LOW_CYC (EL),
    .POLL_MAX   (PM)
  ) dut (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .istart    (istart),
    .irs       (irs),
    .ipoll     (ipoll),
    .odone     (odone),
    .odata     (odata),
    .otimeout  (otimeout),
    .obusy     (obusy),
    .lcd_data_i(lcd_data_i),
    .obus_rel  (obus_rel),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    irst_n = 1'b0;
    istart = 1'b1;
    irs = 1'b0;
    ipoll = 1'b0;
    lcd_data_i = 8'h5A;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_outs", {odone, otimeout, obusy, obus_rel, lcd_rs, lcd_rw, lcd_en}, 0);
    chk("rst_data", int'(odata), 0);
    irst_n = 1'b1;
    begin
      int b;
      b = 0;
      repeat (20) begin
        @(posedge iclk);
        #1;
        if (obusy || lcd_en || lcd_rw) b++;
      end
      chk("rst_hold_start", b, 0);
    end
    istart = 1'b0;
    @(posedge iclk);
    #1;
  endtask

  task automatic run_txn(
    input logic  rs,
    input logic  poll,
    input bit    glitch,
    input string nm
  );
    int n, pulses, rwc, hw, werr, rserr, oerr, dcnt, done_n;
    int exp_p, exp_n;
    logic exp_to;
    logic [7:0] exp_d;
    logic prev_en;
    bit seen;
    if (rs || !poll) begin
      exp_p = 1;
    end else begin
      exp_p = PM;
      for (int i = PM - 1; i >= 0; i--)
        if (!vals[i][7]) exp_p = i + 1;
    end
    exp_d  = vals[exp_p-1];
    exp_to = !rs && poll && vals[exp_p-1][7];
    exp_n  = exp_p * PER + 1;
    n = 0; pulses = 0; rwc = 0; hw = 0; werr = 0;
    rserr = 0; oerr = 0; dcnt = 0; done_n = 0;
    prev_en = 1'b0;
    seen = 1'b0;
    irs = rs;
    ipoll = poll;
    lcd_data_i = 8'($urandom);
    istart = 1'b1;
    while (n < exp_n + 100) begin
      @(posedge iclk);
      #1;
      n++;
      if (n == 2) begin
        chk({nm, "_busy"}, int'(obusy), 1);
        chk({nm, "_to_clr"}, int'(otimeout), 0);
      end
      if (lcd_en && !prev_en) begin
        if (pulses < 16) lcd_data_i = vals[pulses];
        pulses++;
      end
      if (lcd_en) begin
        hw++;
      end else if (prev_en) begin
        if (hw != EH) werr++;
        hw = 0;
      end
      prev_en = lcd_en;
      if (lcd_rw) rwc++;
      if (lcd_rw && lcd_rs !== rs) rserr++;
      if (lcd_en && !obus_rel) oerr++;
      if (obus_rel !== lcd_rw) oerr++;
      if (!lcd_rw && lcd_rs) rserr++;
      if (glitch && n == 25) istart = 1'b0;
      if (glitch && n == 27) istart = 1'b1;
      if (odone) begin
        dcnt++;
        if (!seen) begin
          seen = 1'b1;
          done_n = n;
          chk({nm, "_latency"}, n, exp_n);
          chk({nm, "_data"}, int'(odata), int'(exp_d));
          chk({nm, "_timeout"}, int'(otimeout), int'(exp_to));
          chk({nm, "_busy_done"}, int'(obusy), 1);
        end
      end
      if (seen && n == done_n + 40) break;
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s_no_done got 0 want 1", nm);
    end
    chk({nm, "_pulses"}, pulses, exp_p);
    chk({nm, "_done_cnt"}, dcnt, 1);
    chk({nm, "_en_width"}, werr, 0);
    chk({nm, "_rw_cycles"}, rwc, exp_p * PER);
    chk({nm, "_rs"}, rserr, 0);
    chk({nm, "_order"}, oerr, 0);
    chk({nm, "_idle"}, int'(obusy), 0);
    chk({nm, "_data_hold"}, int'(odata), int'(exp_d));
    chk({nm, "_to_hold"}, int'(otimeout), int'(exp_to));
    istart = 1'b0;
    @(posedge iclk);
    #1;
  endtask

  task automatic test_single_bf();
    vals[0] = 8'h05;
    run_txn(1'b0, 1'b0, 1'b0, "single_bf");
  endtask

  task automatic test_data_read();
    vals[0] = 8'h41;
    vals[1] = 8'h80;
    run_txn(1'b1, 1'b1, 1'b0, "data_read");
  endtask

  task automatic test_poll_clear();
    vals[0] = 8'h80;
    vals[1] = 8'h80;
    vals[2] = 8'h80;
    vals[3] = 8'h12;
    run_txn(1'b0, 1'b1, 1'b0, "poll_clear");
  endtask

  task automatic test_poll_timeout();
    for (int i = 0; i < 16; i++) vals[i] = 8'hFF;
    run_txn(1'b0, 1'b1, 1'b0, "poll_timeout");
  endtask

  task automatic test_handshake();
    vals[0] = 8'($urandom) | 8'h01;
    run_txn(1'b0, 1'b0, 1'b1, "handshake");
  endtask

  task automatic test_reset_mid();
    int b;
    vals[0] = 8'hA5;
    lcd_data_i = 8'hA5;
    irs = 1'b0;
    ipoll = 1'b0;
    istart = 1'b1;
    repeat (10) begin
      @(posedge iclk);
      #1;
    end
    chk("mid_en_before", int'(lcd_en), 1);
    irst_n = 1'b0;
    @(posedge iclk);
    #1;
    chk("mid_outs", {odone, obusy, obus_rel, lcd_rw, lcd_en}, 0);
    chk("mid_data", int'(odata), 0);
    irst_n = 1'b1;
    b = 0;
    repeat (30) begin
      @(posedge iclk);
      #1;
      if (obusy || lcd_en || odone) b++;
    end
    chk("mid_no_restart", b, 0);
    istart = 1'b0;
    @(posedge iclk);
    #1;
    vals[0] = 8'h3C;
    run_txn(1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic r, p;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) begin
        vals[i] = 8'($urandom);
        vals[i][7] = ($urandom_range(0, 2) != 0);
      end
      r = 1'($urandom);
      p = 1'($urandom);
      run_txn(r, p, 1'b0, "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_bf();
    test_data_read();
    test_poll_clear();
    test_poll_timeout();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
